sdp_x_alu_in_arb: RTL and testbench

- Two-requester, packet-locked round-robin arbiter feeding the SDP X-core ALU input channel (chn_alu_in) with 512-bit beats.
- Merges the ALU operand stream from two upstream sources, src0 (DMA read path) and src1 (internal bypass path).
- Never interleaves beats of different packets.
- Drives the channel's valid/data pair from a single output register and honours the channel's load (lz) strobe as the consumer pop.

---
 rtl/sdp_x_arb_pkg.sv | 18 +
 rtl/sdp_x_pipe_reg.sv | 39 +++
 rtl/sdp_x_alu_in_arb.sv | 125 ++++++++++++
 tb/tb_sdp_x_alu_in_arb.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdp_x_arb_pkg.sv
// Shared definitions for the SDP X-core ALU input arbiter: FSM states,
// default sizing constants and source identifiers.
package sdp_x_arb_pkg;

  localparam int DW_DEF        = 512;
  localparam int MAX_BEATS_DEF = 64;
  localparam int CW_DEF        = 7;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sdp_x_pipe_reg.sv
// Single-entry valid/data output register; a new word may load whenever the
// register is empty or its current word is being popped in the same cycle.
module sdp_x_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         can_load_o,
  output logic         vld_o,
  output logic [W-1:0] data_o
);

  logic         vld_q;
  logic [W-1:0] data_q;

  assign can_load_o = !vld_q || pop_i;
  assign vld_o      = vld_q;
  assign data_o     = data_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the data register is reset as well because the channel exposes it
  // directly and must read as zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (load_i) begin
      vld_q  <= 1'b1;
      data_q <= data_i;
    end else if (pop_i) begin
      vld_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/sdp_x_alu_in_arb.sv
// Two-source packet-locked round-robin arbiter driving chn_alu_in through a
// single output register; packets are never interleaved.
module sdp_x_alu_in_arb
  import sdp_x_arb_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int MAX_BEATS = MAX_BEATS_DEF,
  parameter int CW        = CW_DEF
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rst,
  input  logic          arb_en,
  input  logic          err_clr,
  input  logic          src0_vld,
  input  logic          src0_last,
  input  logic [DW-1:0] src0_data,
  output logic          src0_rdy,
  input  logic          src1_vld,
  input  logic          src1_last,
  input  logic [DW-1:0] src1_data,
  output logic          src1_rdy,
  output logic [DW-1:0] chn_alu_in_rsc_z,
  output logic          chn_alu_in_rsc_vz,
  input  logic          chn_alu_in_rsc_lz,
  output logic          arb_busy,
  output logic          cur_src,
  output logic          err_len0,
  output logic          err_len1
);

  arb_state_e    state_q, state_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          err0_q, err0_d, err1_q, err1_d;

  logic          can_load;
  logic          cand0, cand1, win_src, accept, sel, acc_last, over_len;
  logic [DW-1:0] acc_data;

  assign cand0    = src0_vld && arb_en;
  assign cand1    = src1_vld && arb_en;
  assign win_src  = (cand0 && cand1) ? rr_ptr_q : cand1;

  // A locked packet owns the channel; otherwise the round-robin winner does.
  always_comb begin
    src0_rdy = 1'b0;
    src1_rdy = 1'b0;
    unique case (state_q)
      ST_LOCK0: src0_rdy = can_load;
      ST_LOCK1: src1_rdy = can_load;
      default: begin
        if (cand0 || cand1) begin
          src0_rdy = can_load && (win_src == SRC0);
          src1_rdy = can_load && (win_src == SRC1);
        end
      end
    endcase
  end

  assign sel      = src1_rdy ? SRC1 : SRC0;
  assign accept   = (src0_rdy && src0_vld) || (src1_rdy && src1_vld);
  assign acc_last = sel ? src1_last : src0_last;
  assign acc_data = sel ? src1_data : src0_data;
  assign over_len = accept && (beat_cnt_q >= CW'(MAX_BEATS));

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (accept) begin
      if (state_q == ST_IDLE) begin
        if (acc_last) begin
          rr_ptr_d = !sel;
        end else begin
          state_d    = sel ? ST_LOCK1 : ST_LOCK0;
          beat_cnt_d = CW'(1);
        end
      end else if (acc_last) begin
        state_d    = ST_IDLE;
        rr_ptr_d   = !sel;
        beat_cnt_d = '0;
      end else if (beat_cnt_q != '1) begin
        beat_cnt_d = beat_cnt_q + CW'(1);
      end
    end
  end

  // Set beats clear so a simultaneous overflow is never lost.
  assign err0_d = (over_len && sel == SRC0) || (err0_q && !err_clr);
  assign err1_d = (over_len && sel == SRC1) || (err1_q && !err_clr);

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= 1'b0;
      beat_cnt_q <= '0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
    end
  end

  sdp_x_pipe_reg #(.W(DW + 1)) u_out_reg (
    .clk        (nvdla_core_clk),
    .rst        (nvdla_core_rst),
    .load_i     (accept),
    .data_i     ({sel, acc_data}),
    .pop_i      (chn_alu_in_rsc_lz),
    .can_load_o (can_load),
    .vld_o      (chn_alu_in_rsc_vz),
    .data_o     ({cur_src, chn_alu_in_rsc_z})
  );

  assign arb_busy = (state_q != ST_IDLE) || chn_alu_in_rsc_vz;
  assign err_len0 = err0_q;
  assign err_len1 = err1_q;

endmodule

// File: tb/tb_sdp_x_alu_in_arb.sv
// Self-checking bench for sdp_x_alu_in_arb: directed scenarios plus random
// traffic against a packet-level reference model and a contiguity scoreboard.
module tb_sdp_x_alu_in_arb;
  localparam int DW   = 512;
  localparam int MAXB = 64;

  logic clk = 1'b0;
  logic rst, arb_en, err_clr, lz;
  logic v0, l0, v1, l1;
  logic [DW-1:0] d0, d1;
  logic rdy0, rdy1, vz, busy, csrc, e0, e1;
  logic [DW-1:0] z;

  always #5 clk = ~clk;

  sdp_x_alu_in_arb dut (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst), .arb_en(arb_en), .err_clr(err_clr),
    .src0_vld(v0), .src0_last(l0), .src0_data(d0), .src0_rdy(rdy0),
    .src1_vld(v1), .src1_last(l1), .src1_data(d1), .src1_rdy(rdy1),
    .chn_alu_in_rsc_z(z), .chn_alu_in_rsc_vz(vz), .chn_alu_in_rsc_lz(lz),
    .arb_busy(busy), .cur_src(csrc), .err_len0(e0), .err_len1(e1)
  );

  int checks = 0, failures = 0;

  task automatic check1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic checkw(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: which source owns the channel, beats so far, whose turn.
  bit            m_vz;
  logic [DW-1:0] m_z;
  bit            m_src;
  int            m_lock;   // -1 = no packet in flight
  int            m_cnt;
  int            m_rr;
  bit            m_err[2];

  // Source drivers: queue of packet lengths per source.
  int            s_len[2][$];
  int            s_beat[2];
  int            s_pkt[2];
  int            s_pct[2];
  bit            s_pres[2];
  bit            s_last[2];
  logic [DW-1:0] s_data[2];
  bit            det;

  // Beats seen leaving the channel (DUT values).
  logic [DW-1:0] pop_z[$];
  bit            pop_s[$];
  bit            prev_ok;
  bit            prev_src;
  int            prev_beat;

  task automatic model_reset();
    m_vz = 0; m_z = '0; m_src = 0; m_lock = -1; m_cnt = 0; m_rr = 0;
    m_err = '{0, 0};
    for (int s = 0; s < 2; s++) begin
      s_len[s].delete(); s_beat[s] = 0; s_pres[s] = 0; s_last[s] = 0;
    end
  endtask

  task automatic drive_srcs();
    for (int s = 0; s < 2; s++) begin
      if (!s_pres[s] && s_len[s].size() > 0 && $urandom_range(99) < s_pct[s]) begin
        logic [DW-1:0] r;
        s_pres[s] = 1;
        s_last[s] = (s_beat[s] == s_len[s][0] - 1);
        if (det) r = DW'(s_beat[s] + 1);
        else begin
          for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
          r[24:0] = {s[0], s_pkt[s][7:0], s_beat[s][15:0]};
        end
        s_data[s] = r;
      end
    end
    v0 = s_pres[0]; l0 = s_last[0]; d0 = s_data[0];
    v1 = s_pres[1]; l1 = s_last[1]; d1 = s_data[1];
  endtask

  task automatic cycle();
    bit cl, w;
    bit er[2];
    bit acc[2];
    @(negedge clk);
    cl = !m_vz || lz;
    er = '{0, 0};
    if (m_lock >= 0) er[m_lock] = cl;
    else if (arb_en && (v0 || v1)) begin
      w = (v0 && v1) ? m_rr[0] : v1;
      er[w] = cl;
    end
    check1("src0_rdy", rdy0, er[0]);
    check1("src1_rdy", rdy1, er[1]);
    check1("vz", vz, m_vz);
    checkw("z", z, m_z);
    check1("cur_src", csrc, m_src);
    check1("arb_busy", busy, (m_lock >= 0) || m_vz);
    check1("err_len0", e0, m_err[0]);
    check1("err_len1", e1, m_err[1]);
    if (vz === 1'b1 && lz) begin
      pop_z.push_back(z);
      pop_s.push_back(csrc);
      if (!det) begin
        if (z[15:0] != 0)
          check1("contig", prev_ok && prev_src == z[24] && prev_beat + 1 == int'(z[15:0]), 1'b1);
        prev_ok = 1; prev_src = z[24]; prev_beat = int'(z[15:0]);
      end
    end
    acc[0] = er[0] && v0;
    acc[1] = er[1] && v1;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (err_clr) m_err = '{0, 0};
      if (acc[0] || acc[1]) begin
        int s;
        s = acc[1] ? 1 : 0;
        m_vz = 1; m_z = s_data[s]; m_src = s[0];
        if (m_lock < 0) begin
          if (s_last[s]) m_rr = 1 - s;
          else begin m_lock = s; m_cnt = 1; end
        end else begin
          if (m_cnt >= MAXB) m_err[s] = 1;
          if (s_last[s]) begin m_lock = -1; m_rr = 1 - s; m_cnt = 0; end
          else if (m_cnt < 127) m_cnt++;
        end
        s_pres[s] = 0;
        s_beat[s]++;
        if (s_last[s]) begin void'(s_len[s].pop_front()); s_beat[s] = 0; s_pkt[s]++; end
      end else if (m_vz && lz) m_vz = 0;
    end
    #1;
    drive_srcs();
  endtask

  function automatic bit model_idle();
    return s_len[0].size() == 0 && s_len[1].size() == 0 && !m_vz && m_lock < 0;
  endfunction

  task automatic run_until_idle(int budget);
    for (int i = 0; i < budget && !model_idle(); i++) cycle();
    if (!model_idle()) begin
      checks++; failures++;
      $error("FAIL drain_timeout observed=busy expected=idle");
    end
  endtask

  task automatic do_reset();
    rst = 1; cycle(); cycle(); rst = 0;
    pop_z.delete(); pop_s.delete(); prev_ok = 0;
  endtask

  initial begin
    rst = 1; arb_en = 1; err_clr = 0; lz = 1; det = 1;
    v0 = 0; l0 = 0; d0 = '0; v1 = 0; l1 = 0; d1 = '0;
    s_pkt = '{0, 0}; s_pct = '{100, 100}; s_data = '{'0, '0};
    model_reset();
    do_reset();
    cycle();
    check1("rst_vz", vz, 1'b0);
    checkw("rst_z", z, '0);
    check1("rst_busy", busy, 1'b0);

    // 1: single 3-beat src0 packet, then both 1-beat: src1 must win (rr=1)
    s_len[0].push_back(3);
    run_until_idle(20);
    check1("t1_count", pop_z.size() == 3, 1'b1);
    for (int i = 0; i < 3 && i < pop_z.size(); i++) begin
      checkw("t1_data", pop_z[i], DW'(i + 1));
      check1("t1_src", pop_s[i], 1'b0);
    end
    pop_s.delete(); pop_z.delete();
    s_len[0].push_back(1); s_len[1].push_back(1);
    run_until_idle(20);
    check1("t1_rr_first", pop_s.size() == 2 && pop_s[0] == 1'b1 && pop_s[1] == 1'b0, 1'b1);

    // 2: both 2-beat packets from rr=0 -> A0,A1,B0,B1
    do_reset();
    s_len[0].push_back(2); s_len[1].push_back(2);
    run_until_idle(20);
    check1("t2_order", pop_s.size() == 4 && pop_s[0] == 0 && pop_s[1] == 0 &&
           pop_s[2] == 1 && pop_s[3] == 1, 1'b1);

    // 3: backpressure mid-packet
    pop_z.delete(); pop_s.delete();
    s_len[0].push_back(6);
    repeat (3) cycle();
    lz = 0; repeat (4) cycle(); lz = 1;
    run_until_idle(30);
    check1("t3_count", pop_z.size() == 6, 1'b1);
    for (int i = 0; i < 6 && i < pop_z.size(); i++) checkw("t3_data", pop_z[i], DW'(i + 1));

    // 4: arb_en dropped inside a src1 packet; pending src0 waits
    do_reset();
    s_pct = '{0, 100};
    s_len[1].push_back(4); s_len[0].push_back(2);
    repeat (2) cycle();
    arb_en = 0; s_pct = '{100, 100};
    repeat (8) cycle();
    check1("t4_held", pop_s.size() == 4 && !v0 == 1'b0, 1'b1);
    arb_en = 1;
    run_until_idle(20);
    check1("t4_order", pop_s.size() == 6 && pop_s[0] == 1 && pop_s[3] == 1 &&
           pop_s[4] == 0 && pop_s[5] == 0, 1'b1);

    // 5: 66-beat packet sets err_len0, err_clr clears it
    do_reset();
    s_len[0].push_back(66);
    run_until_idle(100);
    check1("t5_count", pop_z.size() == 66, 1'b1);
    check1("t5_err0", e0, 1'b1);
    err_clr = 1; cycle(); err_clr = 0; cycle();
    check1("t5_cleared", e0, 1'b0);

    // 6: reset while locked to src1 with a held beat
    s_len[1].push_back(5);
    repeat (3) cycle();
    check1("t6_pre_vz", vz, 1'b1);
    rst = 1; cycle(); rst = 0;
    cycle();
    check1("t6_vz", vz, 1'b0);
    check1("t6_rdy1", rdy1, 1'b0);
    check1("t6_busy", busy, 1'b0);

    // Random traffic
    do_reset();
    det = 0;
    for (int i = 0; i < 2500; i++) begin
      for (int s = 0; s < 2; s++)
        if (s_len[s].size() < 3 && $urandom_range(9) == 0)
          s_len[s].push_back(($urandom_range(19) == 0) ? int'($urandom_range(68, 64))
                                                       : int'($urandom_range(8, 1)));
      s_pct   = '{int'($urandom_range(100, 30)), int'($urandom_range(100, 30))};
      lz      = ($urandom_range(3) != 0);
      arb_en  = ($urandom_range(4) != 0);
      err_clr = ($urandom_range(40) == 0);
      cycle();
    end
    lz = 1; arb_en = 1; err_clr = 0; s_pct = '{100, 100};
    run_until_idle(1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
